dmem_responder: RTL

Data-memory responder for the pipelined RISC-V core: the memory-side end of the MemRead/MemWrite control signals produced by the instruction decoder. It sits behind the MEM stage and services one load or store at a time over a fixed, parameterised number of wait cycles. It holds `stall` high so the pipeline freezes until the access completes. It performs byte-lane selection and sign or zero extension for LB/LH/LW/LBU/LHU, and byte-enable writes for SB/SH/SW.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bundle for dmem_responder (counters under DMEM_ACCESS_COUNT_EN)
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        access_err;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    modport master (output mem_read, mem_write, funct3, addr, wdata,
                    input  rdata, stall, access_err, rd_count, wr_count);
    modport slave  (input  mem_read, mem_write, funct3, addr, wdata,
                    output rdata, stall, access_err, rd_count, wr_count);
`else
    modport master (output mem_read, mem_write, funct3, addr, wdata,
                    input  rdata, stall, access_err);
    modport slave  (input  mem_read, mem_write, funct3, addr, wdata,
                    output rdata, stall, access_err);
`endif
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory with byte lanes and load extension; DMEM_ACCESS_COUNT_EN adds access counters
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int A_W   = IDX_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [A_W-1:0]  addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            commit;
    logic [A_W-1:0]  a_sel;
    logic [31:0]     wd_sel;
    logic [2:0]      f3_sel;
    logic            rd_sel, wr_sel;
    logic            fault;
    logic [31:0]     word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_val;
    logic [31:0]     wr_lanes;
    logic [3:0]      be;
    logic            we;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:A_W];

    assign req = bus.mem_read | bus.mem_write;

    // In IDLE with WAIT_CYCLES==1 the access completes on the next edge, so the live inputs are used
    assign a_sel  = (state_q == S_IDLE) ? bus.addr[A_W-1:0] : addr_q;
    assign wd_sel = (state_q == S_IDLE) ? bus.wdata         : wdata_q;
    assign f3_sel = (state_q == S_IDLE) ? bus.funct3        : f3_q;
    assign rd_sel = (state_q == S_IDLE) ? bus.mem_read      : rd_q;
    assign wr_sel = (state_q == S_IDLE) ? bus.mem_write     : wr_q;

    assign commit = reset_n &&
                    (((state_q == S_IDLE) && req && (WAIT_CYCLES == 1)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1)));

    always_comb begin
        fault = 1'b0;
        if (rd_sel && wr_sel)
            fault = 1'b1;
        case (f3_sel)
            3'b000, 3'b100: ;
            3'b001, 3'b101: if (a_sel[0]) fault = 1'b1;
            3'b010:         if (a_sel[1:0] != 2'b00) fault = 1'b1;
            default:        fault = 1'b1;
        endcase
    end

    assign word = mem[a_sel[A_W-1:2]];

    always_comb begin
        ld_byte = 8'h00;
        case (a_sel[1:0])
            2'd0: ld_byte = word[7:0];
            2'd1: ld_byte = word[15:8];
            2'd2: ld_byte = word[23:16];
            2'd3: ld_byte = word[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = a_sel[1] ? word[31:16] : word[15:0];
        ld_val  = 32'h0;
        case (f3_sel)
            3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_val = {{16{ld_half[15]}}, ld_half};
            3'b010: ld_val = word;
            3'b100: ld_val = {24'h0, ld_byte};
            3'b101: ld_val = {16'h0, ld_half};
            default: ld_val = 32'h0;
        endcase
    end

    always_comb begin
        wr_lanes = wd_sel;
        be       = 4'b1111;
        case (f3_sel[1:0])
            2'b00: begin
                wr_lanes = {4{wd_sel[7:0]}};
                be       = 4'b0001 << a_sel[1:0];
            end
            2'b01: begin
                wr_lanes = {2{wd_sel[15:0]}};
                be       = a_sel[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_lanes = wd_sel;
                be       = 4'b1111;
            end
        endcase
    end

    assign we = commit && wr_sel && !fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = bus.addr[A_W-1:0];
                    wdata_d = bus.wdata;
                    f3_d    = bus.funct3;
                    rd_d    = bus.mem_read;
                    wr_d    = bus.mem_write;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = (WAIT_CYCLES == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = S_DONE;
            end
            // Inputs still carry the serviced instruction here; ignoring them avoids a double service
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rdata_d = rdata_q;
        if (commit) begin
            if (fault)
                rdata_d = 32'h0;
            else if (rd_sel)
                rdata_d = ld_val;
        end
        err_d = commit && fault;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            f3_q    <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; only the control path is cleared
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[a_sel[A_W-1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.access_err = err_q;
    assign bus.stall      = reset_n && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if ((state_q == S_DONE) && !err_q) begin
            if (rd_q) rd_count_d = rd_count_q + 32'd1;
            if (wr_q) wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count_q <= 32'h0;
            wr_count_q <= 32'h0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
`endif

endmodule
